// File: rtl/async_fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ requesters and the async FIFO write port.
// master: arbiter side (takes requests, drives FIFO); slave: requesters + FIFO.
interface async_fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ-1:0]            i_req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic                          i_fifo_full;
    logic                          o_fifo_wren;
    logic [ID_WIDTH+DATA_WIDTH-1:0] o_fifo_wdata;

    modport master (
        input  i_req_valid,
        input  i_req_last,
        input  i_req_data,
        input  i_fifo_full,
        output o_req_ready,
        output o_fifo_wren,
        output o_fifo_wdata
    );

    modport slave (
        output i_req_valid,
        output i_req_last,
        output i_req_data,
        output i_fifo_full,
        input  o_req_ready,
        input  o_fifo_wren,
        input  o_fifo_wdata
    );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port (i_wrclk domain).
// Ports: i_wrclk, i_wrst_n, bus (requests + FIFO port), o_grant, o_busy, o_beat_cnt.
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                             i_wrclk,
    input  logic                             i_wrst_n,
    async_fifo_wr_arbiter_if.master          bus,
    output logic [NUM_REQ-1:0]               o_grant,
    output logic                             o_busy,
    output logic [$clog2(MAX_BURST):0]       o_beat_cnt
);
    localparam int CNT_WIDTH = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]    idx_q, idx_d;
    logic [ID_WIDTH-1:0]    last_q, last_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                   win_found;
    logic [ID_WIDTH-1:0]    win_idx;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   xfer;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    // Search starts just after the previous winner; first valid wins.
    always_comb begin
        int cand;
        logic [ID_WIDTH-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last_q) + i) % NUM_REQ;
            cand_idx = ID_WIDTH'(cand);
            if (!win_found && bus.i_req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Mux out the granted requester's signals.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_WIDTH'(k) == idx_q) begin
                sel_valid = bus.i_req_valid[k];
                sel_last  = bus.i_req_last[k];
                sel_data  = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer    = (state_q == ST_BURST) && sel_valid && !bus.i_fifo_full;
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge i_wrclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= ID_WIDTH'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_BURST;
                    idx_d   = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    // Truncate at MAX_BURST so others get a turn.
                    if (sel_last || cnt_inc == CNT_WIDTH'(MAX_BURST)) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        last_d  = idx_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Ready/wren are combinational in full so the FIFO never sees wren while full.
    always_comb begin
        o_busy           = (state_q == ST_BURST);
        o_grant          = gnt_q;
        o_beat_cnt       = cnt_q;
        bus.o_req_ready  = '0;
        bus.o_fifo_wren  = 1'b0;
        bus.o_fifo_wdata = {idx_q, sel_data};
        if (state_q == ST_BURST && !bus.i_fifo_full) begin
            bus.o_req_ready = gnt_q;
            bus.o_fifo_wren = sel_valid;
        end
    end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter with a write-word scoreboard.
// Ports: drives the interface slave side, checks FIFO writes and status outputs.
module tb_async_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic i_wrst_n;
    logic [NR-1:0] o_grant;
    logic o_busy;
    logic [$clog2(MB):0] o_beat_cnt;

    async_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    async_fifo_wr_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_WIDTH(IW)
    ) dut (
        .i_wrclk(clk),
        .i_wrst_n(i_wrst_n),
        .bus(bus),
        .o_grant(o_grant),
        .o_busy(o_busy),
        .o_beat_cnt(o_beat_cnt)
    );

    always #5 clk = ~clk;

    int ncomp = 0;
    int nfail = 0;

    logic [7:0] sd [NR][8];
    int slen [NR];
    int sptr [NR];
    logic en [NR];
    logic hold [NR];
    logic full_c;
    logic rst_c;
    logic [NR-1:0] fire;
    logic [IW+DW-1:0] q [$];
    logic [NR-1:0] gh [64];
    int tc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            logic v;
            v = en[k] && !hold[k] && (sptr[k] < slen[k]);
            bus.i_req_valid[k] = v;
            bus.i_req_last[k]  = v && (sptr[k] == slen[k] - 1);
            bus.i_req_data[k*DW +: DW] = v ? sd[k][sptr[k]] : 8'h00;
        end
        bus.i_fifo_full = full_c;
        i_wrst_n = rst_c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++)
            if (fire[k]) sptr[k]++;
        drive();
        @(negedge clk);
        if (bus.o_fifo_wren) begin
            if (q.size() == 0) chk("wr_extra", 32'(q.size()), 1);
            else chk("wdata", 32'(bus.o_fifo_wdata), 32'(q.pop_front()));
        end
        fire = bus.i_req_valid & bus.o_req_ready;
        tc++;
        if (tc < 64) gh[tc] = o_grant;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((q.size() != 0 || o_busy) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_q", 32'(q.size()), 0);
        chk("drain_busy", 32'(o_busy), 0);
    endtask

    task automatic load(input int k, input int n, input logic [7:0] base);
        for (int j = 0; j < n; j++) sd[k][j] = base + 8'(j);
        slen[k] = n;
        sptr[k] = 0;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        q.push_back({IW'(id), d});
    endtask

    task automatic do_reset();
        for (int k = 0; k < NR; k++) begin
            slen[k] = 0; sptr[k] = 0; en[k] = 1'b0; hold[k] = 1'b0;
        end
        full_c = 1'b0;
        rst_c = 1'b0;
        fire = '0;
        q.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_cnt", 32'(o_beat_cnt), 0);
        chk("rst_ready", 32'(bus.o_req_ready), 0);
        chk("rst_wren", 32'(bus.o_fifo_wren), 0);
        rst_c = 1'b1;
        tc = 0;
    endtask

    initial begin
        // Single requester, three beats.
        do_reset();
        load(2, 3, 8'hA1);
        en[2] = 1'b1;
        push(2, 8'hA1); push(2, 8'hA2); push(2, 8'hA3);
        tick();
        chk("s_idle_grant", 32'(o_grant), 0);
        tick();
        chk("s_grant", 32'(o_grant), 32'h4);
        chk("s_busy", 32'(o_busy), 1);
        chk("s_cnt0", 32'(o_beat_cnt), 0);
        chk("s_ready", 32'(bus.o_req_ready), 32'h4);
        tick();
        chk("s_cnt1", 32'(o_beat_cnt), 1);
        tick();
        chk("s_cnt2", 32'(o_beat_cnt), 2);
        tick();
        chk("s_end_grant", 32'(o_grant), 0);
        chk("s_end_cnt", 32'(o_beat_cnt), 3);
        chk("s_end_ready", 32'(bus.o_req_ready), 0);
        chk("s_q", 32'(q.size()), 0);
        load(2, 1, 8'hA4);
        push(2, 8'hA4);
        tick();
        tick();
        chk("s2_grant", 32'(o_grant), 32'h4);
        chk("s2_cnt0", 32'(o_beat_cnt), 0);
        drain(10);

        // Fairness: four 2-beat bursts.
        do_reset();
        for (int k = 0; k < NR; k++) begin
            load(k, 2, 8'(8'h10 * (k + 1)));
            en[k] = 1'b1;
            push(k, 8'(8'h10 * (k + 1)));
            push(k, 8'(8'h10 * (k + 1) + 1));
        end
        repeat (13) tick();
        chk("f_g2", 32'(gh[2]), 32'h1);
        chk("f_g4", 32'(gh[4]), 0);
        chk("f_g5", 32'(gh[5]), 32'h2);
        chk("f_g7", 32'(gh[7]), 0);
        chk("f_g8", 32'(gh[8]), 32'h4);
        chk("f_g11", 32'(gh[11]), 32'h8);
        chk("f_g13", 32'(gh[13]), 0);
        chk("f_q", 32'(q.size()), 0);

        // Truncation at MAX_BURST=4.
        do_reset();
        load(1, 6, 8'hB1);
        load(3, 2, 8'hC1);
        en[1] = 1'b1; en[3] = 1'b1;
        for (int j = 0; j < 4; j++) push(1, 8'(8'hB1 + j));
        push(3, 8'hC1); push(3, 8'hC2);
        push(1, 8'hB5); push(1, 8'hB6);
        repeat (6) tick();
        chk("t_idle_grant", 32'(o_grant), 0);
        chk("t_cnt_max", 32'(o_beat_cnt), MB);
        drain(20);
        chk("t_g7", 32'(gh[7]), 32'h8);
        chk("t_g10", 32'(gh[10]), 32'h2);

        // Backpressure mid-burst, then a stall on the last beat.
        do_reset();
        load(0, 4, 8'hD1);
        en[0] = 1'b1;
        for (int j = 0; j < 4; j++) push(0, 8'(8'hD1 + j));
        repeat (3) tick();
        full_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_wren", 32'(bus.o_fifo_wren), 0);
            chk("b_ready", 32'(bus.o_req_ready), 0);
            chk("b_grant", 32'(o_grant), 32'h1);
            chk("b_cnt", 32'(o_beat_cnt), 2);
        end
        full_c = 1'b0;
        tick();
        chk("b_rel_wren", 32'(bus.o_fifo_wren), 1);
        full_c = 1'b1;
        tick();
        chk("b_last_wren", 32'(bus.o_fifo_wren), 0);
        chk("b_last_busy", 32'(o_busy), 1);
        chk("b_last_cnt", 32'(o_beat_cnt), 3);
        full_c = 1'b0;
        tick();
        chk("b_last_go", 32'(bus.o_fifo_wren), 1);
        tick();
        chk("b_end_busy", 32'(o_busy), 0);
        chk("b_end_cnt", 32'(o_beat_cnt), 4);
        chk("b_q", 32'(q.size()), 0);

        // Bubble: requester 0 idles, requester 1 waits.
        do_reset();
        load(0, 4, 8'hE1);
        load(1, 2, 8'hF1);
        en[0] = 1'b1; en[1] = 1'b1;
        for (int j = 0; j < 4; j++) push(0, 8'(8'hE1 + j));
        push(1, 8'hF1); push(1, 8'hF2);
        repeat (3) tick();
        hold[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("u_grant", 32'(o_grant), 32'h1);
            chk("u_ready", 32'(bus.o_req_ready), 32'h1);
            chk("u_wren", 32'(bus.o_fifo_wren), 0);
        end
        hold[0] = 1'b0;
        drain(20);

        // Reset during the second beat.
        do_reset();
        load(0, 4, 8'h61);
        load(1, 1, 8'h71);
        en[0] = 1'b1; en[1] = 1'b1;
        push(0, 8'h61);
        repeat (2) tick();
        rst_c = 1'b0;
        push(0, 8'h62); push(0, 8'h63); push(0, 8'h64); push(1, 8'h71);
        tick();
        chk("r_grant", 32'(o_grant), 0);
        chk("r_busy", 32'(o_busy), 0);
        chk("r_cnt", 32'(o_beat_cnt), 0);
        chk("r_ready", 32'(bus.o_req_ready), 0);
        chk("r_wren", 32'(bus.o_fifo_wren), 0);
        rst_c = 1'b1;
        tick();
        chk("r_idle", 32'(o_busy), 0);
        tick();
        chk("r_first", 32'(o_grant), 32'h1);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
